// File: rtl/pixel_clk_reconfig_pkg.sv
// rtl/pixel_clk_reconfig_pkg.sv - shared types and MMCM DRP programming table
// Purpose: pixel clock modes, DRP table entry layout, FSM state encoding and
//          the per-mode list of MMCM registers rewritten on reconfiguration.
// Ports:   none (package).
package common;

  // 640x480 runs at 25.2 MHz (VCO 1260 MHz = 100 * 63 / 5, O = 50);
  // 800x600 runs at 40 MHz   (VCO  800 MHz = 100 *  8 / 1, O = 20).
  typedef enum logic [0:0] {
    PXL_MODE_640X480 = 1'b0,
    PXL_MODE_800X600 = 1'b1
  } pxl_mode_t;

  // mask bits set = keep the bit read back from the MMCM.
  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  localparam int PXL_DRP_REGS = 8;
  localparam int PXL_IDX_W    = $clog2(PXL_DRP_REGS);

  typedef enum logic [3:0] {
    RESET_HOLD,
    IDLE,
    ASSERT_RST,
    READ,
    WAIT_READ,
    WRITE,
    WAIT_WRITE,
    RELEASE,
    WAIT_LOCK
  } pxl_state_t;

  // Order: POWER, CLKOUT0_REG1, CLKOUT0_REG2, CLKFBOUT_REG1, CLKFBOUT_REG2,
  //        DIVCLK, LOCK_REG1, FILT_REG1.
  localparam drp_entry_t PXL_DRP_TABLE [2][PXL_DRP_REGS] = '{
    '{
      '{7'h28, 16'h0000, 16'hFFFF},
      '{7'h08, 16'h1000, 16'h0659},
      '{7'h09, 16'hFC00, 16'h0000},
      '{7'h14, 16'h1000, 16'h07E0},
      '{7'h15, 16'hFC00, 16'h0080},
      '{7'h16, 16'hC000, 16'h2083},
      '{7'h18, 16'hFC00, 16'h03E8},
      '{7'h4E, 16'h66FF, 16'h0900}
    },
    '{
      '{7'h28, 16'h0000, 16'hFFFF},
      '{7'h08, 16'h1000, 16'h028A},
      '{7'h09, 16'hFC00, 16'h0000},
      '{7'h14, 16'h1000, 16'h0104},
      '{7'h15, 16'hFC00, 16'h0000},
      '{7'h16, 16'hC000, 16'h1041},
      '{7'h18, 16'hFC00, 16'h01F4},
      '{7'h4E, 16'h66FF, 16'h9000}
    }
  };

endpackage

// File: rtl/pixel_clk_reconfig_sync_bit.sv
// rtl/pixel_clk_reconfig_sync_bit.sv - multi-flop synchronizer for one async bit
// Purpose: brings an asynchronous level into the clk_sys_i domain.
// Ports:   clk_sys_i     - destination clock
//          reset_async_i - asynchronous active-high reset, clears all stages
//          d             - asynchronous input level
//          q             - synchronized level, SYNC_STAGES cycles late
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys_i,
  input  logic reset_async_i,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk_sys_i or posedge reset_async_i) begin
    if (reset_async_i) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/pixel_clk_reconfig.sv
// rtl/pixel_clk_reconfig.sv - MMCM pixel clock reconfiguration sequencer
// Purpose: on request, holds the MMCM in reset, read-modify-writes the
//          per-mode DRP register list, releases reset and waits for lock.
// Ports:   clk_sys_i/reset_async_i   - system clock, async active-high reset
//          req_i/mode_i              - reconfiguration request and target mode
//          busy_o/done_o/error_o     - status: in progress, end pulse, lock timeout
//          ready_o                   - pixel clock locked and sequencer idle
//          mmcm_rst_o/locked_async_i - MMCM RST drive and raw LOCKED
//          drp_*                     - MMCM dynamic reconfiguration port
module pixel_clk_reconfig
  import common::*;
#(
  parameter int LOCK_TIMEOUT = 100000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk_sys_i,
  input  logic        reset_async_i,
  input  logic        req_i,
  input  pxl_mode_t   mode_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        ready_o,
  output logic        mmcm_rst_o,
  input  logic        locked_async_i,
  output logic [6:0]  drp_addr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  output logic        drp_en_o,
  output logic        drp_we_o,
  input  logic        drp_rdy_i
);

  localparam int                   CNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [PXL_IDX_W-1:0] IDX_LAST = PXL_IDX_W'(PXL_DRP_REGS - 1);

  pxl_state_t           state;
  pxl_mode_t            mode_q;
  logic [PXL_IDX_W-1:0] idx;
  logic [CNT_W-1:0]     lock_cnt;
  logic                 seq_active;  // done_o only for requested sequences, not power-up
  logic                 locked_sync;
  drp_entry_t           entry;
  logic [15:0]          merged;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_sys_i    (clk_sys_i),
    .reset_async_i(reset_async_i),
    .d            (locked_async_i),
    .q            (locked_sync)
  );

  assign entry  = PXL_DRP_TABLE[mode_q][idx];
  assign merged = (drp_do_i & entry.mask) | (entry.data & ~entry.mask);

  // MMCM RST edges are registered on leaving ASSERT_RST / RESET_HOLD / RELEASE,
  // so the lock timeout counts from the cycle the MMCM actually sees RST low.
  always_ff @(posedge clk_sys_i or posedge reset_async_i) begin
    if (reset_async_i) begin
      state      <= RESET_HOLD;
      mode_q     <= PXL_MODE_640X480;
      idx        <= '0;
      lock_cnt   <= '0;
      seq_active <= 1'b0;
      mmcm_rst_o <= 1'b1;
      busy_o     <= 1'b1;
      ready_o    <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      drp_en_o   <= 1'b0;
      drp_we_o   <= 1'b0;
      drp_addr_o <= '0;
      drp_di_o   <= '0;
    end else begin
      done_o   <= 1'b0;
      drp_en_o <= 1'b0;
      drp_we_o <= 1'b0;
      ready_o  <= locked_sync && (state == IDLE);

      case (state)
        RESET_HOLD: begin
          mmcm_rst_o <= 1'b0;
          lock_cnt   <= '0;
          state      <= WAIT_LOCK;
        end

        IDLE: begin
          if (req_i) begin
            mode_q     <= mode_i;
            busy_o     <= 1'b1;
            idx        <= '0;
            error_o    <= 1'b0;
            seq_active <= 1'b1;
            state      <= ASSERT_RST;
          end
        end

        ASSERT_RST: begin
          mmcm_rst_o <= 1'b1;
          drp_en_o   <= 1'b1;
          drp_addr_o <= entry.addr;
          state      <= READ;
        end

        READ: state <= WAIT_READ;

        WAIT_READ: begin
          if (drp_rdy_i) begin
            drp_di_o <= merged;
            drp_en_o <= 1'b1;
            drp_we_o <= 1'b1;
            state    <= WRITE;
          end
        end

        WRITE: state <= WAIT_WRITE;

        WAIT_WRITE: begin
          if (drp_rdy_i) begin
            if (idx == IDX_LAST) begin
              state <= RELEASE;
            end else begin
              idx        <= idx + 1'b1;
              drp_en_o   <= 1'b1;
              drp_addr_o <= PXL_DRP_TABLE[mode_q][idx + 1'b1].addr;
              state      <= READ;
            end
          end
        end

        RELEASE: begin
          mmcm_rst_o <= 1'b0;
          lock_cnt   <= '0;
          state      <= WAIT_LOCK;
        end

        WAIT_LOCK: begin
          // Lock is tested first so it wins a same-cycle tie with the timeout.
          if (locked_sync) begin
            busy_o     <= 1'b0;
            done_o     <= seq_active;
            seq_active <= 1'b0;
            state      <= IDLE;
          end else if (lock_cnt == CNT_LAST) begin
            busy_o     <= 1'b0;
            done_o     <= seq_active;
            error_o    <= 1'b1;
            seq_active <= 1'b0;
            state      <= IDLE;
          end else if (lock_cnt != '1) begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        default: begin
          mmcm_rst_o <= 1'b1;
          busy_o     <= 1'b1;
          state      <= RESET_HOLD;
        end
      endcase
    end
  end

endmodule
